// File: rtl/seg7_display_driver.sv
// Four-digit multiplexed hex display driver: captures a 16-bit word and a sticky halt flag.
// Optional leading-zero blanking is enabled by defining SEG7_LEADING_ZERO_BLANK_EN.
module seg7_display_driver #(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] data_in,
    input  logic        load,
    input  logic        halt,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

    logic [15:0]   disp_q;
    logic          halt_q;
    logic [CW-1:0] cnt;
    logic [1:0]    sel;

    logic [3:0]    nib;
    logic          blank;
    logic [6:0]    seg_nxt;
    logic [3:0]    an_nxt;
    logic          dp_nxt;

    // Patterns are g..a, active-low.
    function automatic logic [6:0] hex_pattern(input logic [3:0] v);
        logic [6:0] p;
        case (v)
            4'h0:    p = 7'b1000000;
            4'h1:    p = 7'b1111001;
            4'h2:    p = 7'b0100100;
            4'h3:    p = 7'b0110000;
            4'h4:    p = 7'b0011001;
            4'h5:    p = 7'b0010010;
            4'h6:    p = 7'b0000010;
            4'h7:    p = 7'b1111000;
            4'h8:    p = 7'b0000000;
            4'h9:    p = 7'b0010000;
            4'hA:    p = 7'b0001000;
            4'hB:    p = 7'b0000011;
            4'hC:    p = 7'b1000110;
            4'hD:    p = 7'b0100001;
            4'hE:    p = 7'b0000110;
            default: p = 7'b0001110;
        endcase
        return p;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_q <= '0;
            halt_q <= 1'b0;
        end else begin
            if (load) disp_q <= data_in;
            if (halt) halt_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            sel <= 2'd0;
        end else if (cnt == CNT_MAX) begin
            cnt <= '0;
            sel <= sel + 2'd1;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    always_comb begin
        nib   = 4'h0;
        blank = 1'b0;
        case (sel)
            2'd0:    nib = disp_q[3:0];
            2'd1:    nib = disp_q[7:4];
            2'd2:    nib = disp_q[11:8];
            default: nib = disp_q[15:12];
        endcase
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        // A digit goes dark only if it and every digit to its left are zero.
        case (sel)
            2'd1:    blank = (disp_q[15:4] == 12'h000);
            2'd2:    blank = (disp_q[15:8] == 8'h00);
            2'd3:    blank = (disp_q[15:12] == 4'h0);
            default: blank = 1'b0;
        endcase
`else
        blank = 1'b0;
`endif
        seg_nxt = blank ? 7'b1111111 : hex_pattern(nib);
        an_nxt  = ~(4'b0001 << sel);
        dp_nxt  = ~((sel == 2'd0) && halt_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg <= 7'b1111111;
            an  <= 4'b1111;
            dp  <= 1'b1;
        end else begin
            seg <= seg_nxt;
            an  <= an_nxt;
            dp  <= dp_nxt;
        end
    end

endmodule

// File: tb/tb_seg7_display_driver.sv
// Scoreboard bench for seg7_display_driver with REFRESH_DIV=4: cycle-stamped expectations
// are queued by the stimulus and checked by an independent monitor on the falling edge.
module tb_seg7_display_driver;

    logic        clk;
    logic        rst;
    logic [15:0] data_in;
    logic        load;
    logic        halt;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;

    seg7_display_driver #(.REFRESH_DIV(4)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .load(load),
        .halt(halt), .seg(seg), .dp(dp), .an(an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        string      name;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc;

    localparam logic [3:0] A0 = 4'b1110, A1 = 4'b1101, A2 = 4'b1011, A3 = 4'b0111;
    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S5 = 7'b0010010;
    localparam logic [6:0] S7 = 7'b1111000, S8 = 7'b0000000, SA = 7'b0001000, SF = 7'b0001110;
    localparam logic [6:0] DARK = 7'b1111111;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    localparam logic [6:0] LZ = 7'b1111111;
`else
    localparam logic [6:0] LZ = 7'b1000000;
`endif

    // Edge count since reset release: after edge e the pins show digit ((e-1)/4)%4.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic push(input int c, input logic [3:0] a, input logic [6:0] s,
                        input logic d, input string nm);
        exp_t e;
        e.cyc = c; e.an = a; e.seg = s; e.dp = d; e.name = nm;
        q.push_back(e);
    endtask

    task automatic wait_cyc(input int c);
        int guard = 0;
        while (cyc != c) begin
            @(negedge clk);
            guard++;
            if (guard > 2000) begin
                $display("FAIL wait_cyc: cycle=%0d required=%0d", cyc, c);
                $fatal(1, "bench stalled");
            end
        end
    endtask

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            e = q.pop_front();
            n_cmp++;
            if (e.cyc < cyc) begin
                n_err++;
                $display("FAIL %s: missed, cycle now %0d, required cycle %0d", e.name, cyc, e.cyc);
            end else if (an !== e.an || seg !== e.seg || dp !== e.dp) begin
                n_err++;
                $display("FAIL %s @%0d: got an=%b seg=%b dp=%b, required an=%b seg=%b dp=%b",
                         e.name, cyc, an, seg, dp, e.an, e.seg, e.dp);
            end
        end
    end

    initial begin
        rst = 1'b0; data_in = 16'h0000; load = 1'b0; halt = 1'b0;
        #2 rst = 1'b1;
        push(0, 4'b1111, DARK, 1'b1, "reset_dark");
        repeat (3) @(negedge clk);

        push(1,  A0, S0, 1'b1, "first_scan");
        push(4,  A0, S0, 1'b1, "d0_last");
        push(5,  A1, LZ, 1'b1, "step_d1");
        push(8,  A1, LZ, 1'b1, "d1_last");
        push(9,  A2, LZ, 1'b1, "step_d2");
        push(13, A3, LZ, 1'b1, "step_d3");
        push(16, A3, LZ, 1'b1, "d3_last");
        rst = 1'b0;

        wait_cyc(15);
        data_in = 16'hA5F1; load = 1'b1;
        push(17, A0, S1, 1'b1, "dec_d0");
        push(21, A1, SF, 1'b1, "dec_d1");
        push(25, A2, S5, 1'b1, "dec_d2");
        push(29, A3, SA, 1'b1, "dec_d3");
        push(33, A0, S1, 1'b1, "dec_wrap");
        wait_cyc(16);
        load = 1'b0;

        wait_cyc(32);
        data_in = 16'h1234;
        push(37, A1, SF, 1'b1, "nostrobe_d1");
        push(41, A2, S5, 1'b1, "nostrobe_d2");
        push(45, A3, SA, 1'b1, "nostrobe_d3");
        push(49, A0, S1, 1'b1, "nostrobe_d0");
        push(53, A1, SF, 1'b1, "nostrobe_d1b");
        push(57, A2, S5, 1'b1, "nostrobe_d2b");
        push(61, A3, SA, 1'b1, "nostrobe_d3b");

        wait_cyc(64);
        halt = 1'b1;
        push(65, A0, S1, 1'b1, "halt_latency");
        push(66, A0, S1, 1'b0, "halt_dp");
        push(68, A0, S1, 1'b0, "halt_d0_last");
        push(69, A1, SF, 1'b1, "halt_d1");
        push(73, A2, S5, 1'b1, "halt_d2");
        push(77, A3, SA, 1'b1, "halt_d3");
        push(81, A0, S1, 1'b0, "halt_frame2");
        push(97, A0, S1, 1'b0, "halt_frame3");
        wait_cyc(65);
        halt = 1'b0;

        wait_cyc(97);
        data_in = 16'h0008; load = 1'b1;
        push(98,  A0, S1, 1'b0, "mid_before");
        push(99,  A0, S8, 1'b0, "mid_load");
        push(100, A0, S8, 1'b0, "mid_hold");
        push(101, A1, LZ, 1'b1, "lz_0008_d1");
        push(109, A3, LZ, 1'b1, "lz_0008_d3");
        wait_cyc(98);
        load = 1'b0;

        wait_cyc(104);
        data_in = 16'h0007; load = 1'b1;
        push(113, A0, S7, 1'b0, "blank_d0");
        push(117, A1, LZ, 1'b1, "blank_d1");
        push(121, A2, LZ, 1'b1, "blank_d2");
        push(125, A3, LZ, 1'b1, "blank_d3");
        wait_cyc(105);
        load = 1'b0;

        wait_cyc(134);
        rst = 1'b1;
        #1;
        push(0, 4'b1111, DARK, 1'b1, "midreset_dark");
        @(negedge clk);
        push(1, A0, S0, 1'b1, "rst_first");
        push(4, A0, S0, 1'b1, "rst_d0_last");
        push(5, A1, LZ, 1'b1, "rst_cnt_restart");
        rst = 1'b0;

        for (int i = 0; i < 60 && q.size() > 0; i++) @(negedge clk);
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_cmp++;
            n_err++;
            $display("FAIL %s: never reached, cycle now %0d, required cycle %0d", e.name, cyc, e.cyc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/seg7_display_driver.md
# seg7_display_driver

Four-digit, time-multiplexed seven-segment driver for the board's display, downstream of the `Processor` core. Captures the 16-bit data-memory read word on a load strobe and shows it as four hexadecimal digits. Also latches the core's halt flag onto the rightmost decimal point. All outputs are registered, active-low, and drive the board pins directly.

## Interface
- `REFRESH_DIV`, default 100000: clock cycles each digit stays selected (1 ms at 100 MHz). Legal range ≥ 2.
- `clk` input 1: system clock (`CLK100MHZ`); all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset (`btnC`).
- `data_in` input 16: word to display (DMEM read data, low 16 bits).
- `load` input 1: capture strobe; when high at a rising edge, `data_in` is captured.
- `halt` input 1: halt flag from the decoder.
- `seg` output 7: segment cathodes, active-low, `seg[0]`=a … `seg[6]`=g.
- `dp` output 1: decimal-point cathode, active-low.
- `an` output 4: digit anodes, active-low; `an[0]` = rightmost digit.

## Operation
- **Display register:** 16-bit `disp_q`. On each edge with `load`=1, `disp_q` ← `data_in`; otherwise it holds. `load` held high tracks `data_in` every cycle.
- **Halt latch:** `halt_q` sets on any edge with `halt`=1 and clears only on `rst`. It is sticky.
- **Refresh counter:** `cnt` runs 0..`REFRESH_DIV`-1, width `$clog2(REFRESH_DIV)`.
  - At terminal count it wraps to 0 and the 2-bit digit index `sel` advances 0→1→2→3→0.
  - Otherwise `cnt` increments and `sel` holds.
- **Digit select:** `sel`=i selects nibble `disp_q[4i+3:4i]`.
- **Output register, loaded every edge:**
  - `an` ← all ones except bit `sel`, which is 0.
  - `seg` ← hex pattern of the selected nibble, written g..a for `seg[6:0]`:
    - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000
    - 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000
    - 8 = 0000000, 9 = 0010000, A = 0001000, b = 0000011
    - C = 1000110, d = 0100001, E = 0000110, F = 0001110
  - `dp` ← 0 only when `sel`=0 and `halt_q`=1; otherwise 1.
- **Simultaneous events:**
  - A `load` and a digit advance on the same edge are independent. The next output register update uses the new `disp_q` and the new `sel`.
  - A `load` arriving mid-digit changes the selected digit's pattern without waiting for the next refresh slot.

## Timing
- **Reset values** (asynchronous, immediate on `rst`):
  - `disp_q`=0, `halt_q`=0, `cnt`=0, `sel`=0
  - `an`=1111, `seg`=1111111, `dp`=1 (display dark)
- **First edge after reset release:** `an`=1110, `seg`=1000000 (digit 0 showing "0").
- **Latency:** `load` at edge k updates `disp_q` at edge k; the output pins reflect it at edge k+1 if that digit is selected.
- **Halt latency:** `halt` at edge k gives `dp`=0 at edge k+1 when `sel`=0, otherwise at the first edge after `sel` returns to 0.
- **Digit period:** `sel` changes every `REFRESH_DIV` cycles and `an` follows one cycle later. A full frame is 4·`REFRESH_DIV` cycles.
- **Reset mid-frame:** all state returns to the reset values regardless of `cnt` or `sel`.

## Configuration
- **`SEG7_LEADING_ZERO_BLANK_EN` defined:**
  - Digit i (i = 1..3) is blanked (`seg`=1111111) when nibbles i..3 of `disp_q` are all zero.
  - `an` keeps scanning normally, so per-digit brightness is unchanged.
  - Digit 0 is never blanked.
  - `dp` behaviour is unchanged.
- **Macro undefined:** all four digits always display their hex value, including leading zeros.

## Test plan
- **Reset and first scan** (`REFRESH_DIV`=4): assert `rst`, release, then check:
  - during reset: `an`=1111, `seg`=1111111, `dp`=1
  - one edge after release: `an`=1110, `seg`=1000000
  - `an` steps to 1101 → 1011 → 0111 → 1110 at 4-cycle intervals
- **Load and decode:** pulse `load` with `data_in`=16'hA5F1 and scan one frame. Expected digits 0..3: `seg`=1111001 (1), 0001110 (F), 0010010 (5), 0001000 (A).
- **Load without strobe:** change `data_in` to 16'h1234 with `load`=0 for two frames. The display still shows A5F1.
- **Halt latch:**
  - pulse `halt` for 1 cycle
  - `dp`=0 whenever `an`=1110 and `dp`=1 on the other digits
  - the effect persists across frames until `rst`
- **Mid-digit load:** while `an`=1110 is held, load 16'h0008. Exactly one edge after the load edge, `seg`=0000000.
- **Blanking:** load 16'h0007.
  - With `SEG7_LEADING_ZERO_BLANK_EN` defined: digits 1–3 give `seg`=1111111 and digit 0 gives 1111000.
  - Without the macro: digits 1–3 give 1000000.
